// File: rtl/gamepad_pkg.sv
// Shared constants for the Gamepad Pmod receiver: slot width, button bit
// positions inside a 12-bit pad slot, D-pad mask and the "no pad" pattern.
package gamepad_pkg;

   localparam int BITS_PER_PAD = 12;

   // Bit positions inside one pad slot, MSB first on the wire.
   localparam int BTN_B     = 11;
   localparam int BTN_Y     = 10;
   localparam int BTN_SEL   = 9;
   localparam int BTN_START = 8;
   localparam int BTN_UP    = 7;
   localparam int BTN_DN    = 6;
   localparam int BTN_LT    = 5;
   localparam int BTN_RT    = 4;
   localparam int BTN_A     = 3;
   localparam int BTN_X     = 2;
   localparam int BTN_L     = 1;
   localparam int BTN_R     = 0;

   typedef logic [BITS_PER_PAD-1:0] pad_word_t;

   localparam pad_word_t DPAD_MASK  = pad_word_t'((1 << BTN_UP) | (1 << BTN_DN) |
                                                  (1 << BTN_LT) | (1 << BTN_RT));
   localparam pad_word_t PAD_ABSENT = 12'hFFF;

   // An unplugged controller reads all ones; report it as no buttons held.
   function automatic pad_word_t decode_slot(input pad_word_t raw);
      return (raw == PAD_ABSENT) ? '0 : raw;
   endfunction

endpackage

// File: rtl/gamepad_pmod_multi_rx_if.sv
// Pin and decoded-output bundle of the Gamepad Pmod receiver.
// master = pin driver / consumer side, slave = the receiver itself.
interface gamepad_pmod_multi_rx_if
   import gamepad_pkg::*;
#(
   parameter int NUM_PADS = 2
);

   logic                           pmod_data;
   logic                           pmod_clk;
   logic                           pmod_latch;
   logic [BITS_PER_PAD*NUM_PADS-1:0] buttons;
   logic [NUM_PADS-1:0]            present;
   logic [BITS_PER_PAD*NUM_PADS-1:0] pressed;
   logic [BITS_PER_PAD*NUM_PADS-1:0] released;
   logic                           frame_valid;
   logic                           frame_err;

   modport master (
      output pmod_data, pmod_clk, pmod_latch,
      input  buttons, present, pressed, released, frame_valid, frame_err
   );

   modport slave (
      input  pmod_data, pmod_clk, pmod_latch,
      output buttons, present, pressed, released, frame_valid, frame_err
   );

endinterface

// File: rtl/gamepad_pmod_multi_rx_pad_slot.sv
// One controller slot: decodes presence and held buttons from a committed
// frame slice and produces one-cycle press/release pulses.
// Optional D-pad auto-repeat when GAMEPAD_AUTOREPEAT_EN is defined.
module gamepad_pad_slot
   import gamepad_pkg::*;
#(
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 5
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      vld_p0,
   input  pad_word_t slot_p0,
   output pad_word_t buttons,
   output logic      present,
   output pad_word_t pressed,
   output pad_word_t released
);

   pad_word_t new_p0;
   logic      present_p0;
   pad_word_t rpt_mask_p0;

   assign new_p0     = decode_slot(slot_p0);
   assign present_p0 = (slot_p0 != PAD_ABSENT);

`ifdef GAMEPAD_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
   localparam logic [RPT_W-1:0] RPT_MAX    = '1;

   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_cnt_d;
   logic [RPT_W-1:0] rpt_inc;
   pad_word_t        dpad_new;
   pad_word_t        dpad_old;

   assign dpad_new = new_p0 & DPAD_MASK;
   assign dpad_old = buttons & DPAD_MASK;

   // Count committed frames with a steady, non-empty D-pad; fire and reload at the delay.
   always_comb begin
      rpt_cnt_d   = rpt_cnt;
      rpt_mask_p0 = '0;
      rpt_inc     = (rpt_cnt == RPT_MAX) ? rpt_cnt : rpt_cnt + RPT_W'(1);
      if (vld_p0) begin
         if ((dpad_new != '0) && (dpad_new == dpad_old)) begin
            if (rpt_inc == RPT_DELAY) begin
               rpt_mask_p0 = dpad_new;
               rpt_cnt_d   = RPT_RELOAD;
            end else begin
               rpt_cnt_d = rpt_inc;
            end
         end else begin
            rpt_cnt_d = '0;
         end
      end
   end

   // Repeat counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rpt_cnt <= '0;
      end else begin
         rpt_cnt <= rpt_cnt_d;
      end
   end
`else
   assign rpt_mask_p0 = '0;
`endif

   // Decoded state and edge pulses, updated only on committed frames.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buttons  <= '0;
         present  <= 1'b0;
         pressed  <= '0;
         released <= '0;
      end else if (vld_p0) begin
         buttons  <= new_p0;
         present  <= present_p0;
         pressed  <= (new_p0 & ~buttons) | rpt_mask_p0;
         released <= buttons & ~new_p0;
      end else begin
         pressed  <= '0;
         released <= '0;
      end
   end

endmodule

// File: rtl/gamepad_pmod_multi_rx.sv
// Gamepad Pmod receiver for 1..4 controllers: pin synchronisers, frame
// shifter with bit counter, length-checked commit, per-pad decode slots.
// Define GAMEPAD_AUTOREPEAT_EN to enable D-pad auto-repeat on pressed.
module gamepad_pmod_multi_rx
   import gamepad_pkg::*;
#(
   parameter int NUM_PADS      = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   gamepad_pmod_multi_rx_if.slave bus
);

   localparam int FRAME_BITS = BITS_PER_PAD * NUM_PADS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

   if ((NUM_PADS < 1) || (NUM_PADS > 4)) begin : g_bad_pads
      $error("NUM_PADS must be 1..4");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if ((REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
      $error("REPEAT_PERIOD must be 1..REPEAT_DELAY");
   end

   logic [SYNC_STAGES-1:0] data_sync;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] latch_sync;
   logic                   clk_prev;
   logic                   latch_prev;
   logic                   data_s;
   logic                   clk_rise;
   logic                   latch_rise;

   logic [FRAME_BITS-1:0]  shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic [FRAME_BITS-1:0]  frame_p0;
   logic                   vld_p0;
   logic                   err_p0;

   logic [FRAME_BITS-1:0]  buttons_p1;
   logic [NUM_PADS-1:0]    present_p1;
   logic [FRAME_BITS-1:0]  pressed_p1;
   logic [FRAME_BITS-1:0]  released_p1;
   logic                   vld_p1;
   logic                   err_p1;

   // Pin synchronisers plus one extra copy of clk/latch for rise detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_sync  <= '0;
         clk_sync   <= '0;
         latch_sync <= '0;
         clk_prev   <= 1'b0;
         latch_prev <= 1'b0;
      end else begin
         data_sync  <= {data_sync[SYNC_STAGES-2:0], bus.pmod_data};
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.pmod_clk};
         latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.pmod_latch};
         clk_prev   <= clk_sync[SYNC_STAGES-1];
         latch_prev <= latch_sync[SYNC_STAGES-1];
      end
   end

   assign data_s     = data_sync[SYNC_STAGES-1];
   assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
   assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;

   // ---- stage p0: shift bits, count them, commit or reject on latch ----
   // Latch has priority: a pmod_clk rise in the same cycle is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift    <= '1;
         bit_cnt  <= '0;
         frame_p0 <= '1;
         vld_p0   <= 1'b0;
         err_p0   <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         err_p0 <= 1'b0;
         if (latch_rise) begin
            if (bit_cnt == CNT_FULL) begin
               frame_p0 <= shift;
               vld_p0   <= 1'b1;
            end else begin
               err_p0   <= 1'b1;
            end
            bit_cnt <= '0;
         end else if (clk_rise) begin
            shift <= {shift[FRAME_BITS-2:0], data_s};
            if (bit_cnt != CNT_SAT) begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   // ---- stage p1: per-pad decode and edge pulses ----
   for (genvar p = 0; p < NUM_PADS; p++) begin : g_slot
      gamepad_pad_slot #(
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .vld_p0   (vld_p0),
         .slot_p0  (frame_p0[BITS_PER_PAD*p +: BITS_PER_PAD]),
         .buttons  (buttons_p1[BITS_PER_PAD*p +: BITS_PER_PAD]),
         .present  (present_p1[p]),
         .pressed  (pressed_p1[BITS_PER_PAD*p +: BITS_PER_PAD]),
         .released (released_p1[BITS_PER_PAD*p +: BITS_PER_PAD])
      );
   end

   // Frame status pulses aligned with the decoded outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         err_p1 <= err_p0;
      end
   end

   assign bus.buttons     = buttons_p1;
   assign bus.present     = present_p1;
   assign bus.pressed     = pressed_p1;
   assign bus.released    = released_p1;
   assign bus.frame_valid = vld_p1;
   assign bus.frame_err   = err_p1;

endmodule

// File: tb/tb_gamepad_pmod_multi_rx.sv
// Directed bench for gamepad_pmod_multi_rx with two pads.
// The auto-repeat expectations follow GAMEPAD_AUTOREPEAT_EN.
module tb_gamepad_pmod_multi_rx;

   logic clk = 1'b0;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] pr_or;
   logic [23:0] rl_or;
   int          fv_n;
   int          fe_n;
   int          fv_at;
   int          pr_cyc;

   always #5 clk = ~clk;

   gamepad_pmod_multi_rx_if #(.NUM_PADS(2)) bus ();

   gamepad_pmod_multi_rx #(
      .NUM_PADS      (2),
      .SYNC_STAGES   (2),
      .REPEAT_DELAY  (3),
      .REPEAT_PERIOD (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      bus.pmod_data = b;
      repeat (3) @(negedge clk);
      bus.pmod_clk = 1'b1;
      repeat (3) @(negedge clk);
      bus.pmod_clk = 1'b0;
   endtask

   // Shifts the top n bits of w, MSB first (pad 0 goes last).
   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 23; i > 23 - n; i--) begin
         send_bit(w[i]);
      end
   endtask

   // Raises latch (optionally pmod_clk in the same cycle) and records outputs.
   task automatic latch_frame(input logic with_clk);
      @(negedge clk);
      if (with_clk) begin
         bus.pmod_data = 1'b1;
         repeat (3) @(negedge clk);
      end
      bus.pmod_latch = 1'b1;
      if (with_clk) bus.pmod_clk = 1'b1;
      pr_or = '0; rl_or = '0; fv_n = 0; fe_n = 0; fv_at = 0; pr_cyc = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         pr_or = pr_or | bus.pressed;
         rl_or = rl_or | bus.released;
         if (bus.pressed != '0) pr_cyc++;
         if (bus.frame_valid) begin
            fv_n++;
            fv_at = i;
         end
         if (bus.frame_err) fe_n++;
      end
      bus.pmod_latch = 1'b0;
      bus.pmod_clk   = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   logic [7:0] rpt_exp;

   initial begin
      bus.pmod_data  = 1'b0;
      bus.pmod_clk   = 1'b0;
      bus.pmod_latch = 1'b0;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_buttons",  bus.buttons, 32'h0);
      check("rst_present",  bus.present, 32'h0);
      check("rst_pressed",  bus.pressed, 32'h0);
      check("rst_released", bus.released, 32'h0);
      check("rst_fv",       bus.frame_valid, 32'h0);
      check("rst_fe",       bus.frame_err, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Pad 0 holds up, pad 1 absent.
      send_bits({12'hFFF, 12'h080}, 24);
      latch_frame(1'b0);
      check("t1_buttons", bus.buttons, 32'h000080);
      check("t1_present", bus.present, 32'h1);
      check("t1_pressed", pr_or, 32'h000080);
      check("t1_pr_cyc",  pr_cyc, 32'd1);
      check("t1_released", rl_or, 32'h0);
      check("t1_fv_n",    fv_n, 32'd1);
      check("t1_fv_lat",  fv_at, 32'd4);
      check("t1_fe_n",    fe_n, 32'd0);

      // Up released.
      send_bits({12'hFFF, 12'h000}, 24);
      latch_frame(1'b0);
      check("t2_buttons",  bus.buttons, 32'h0);
      check("t2_present",  bus.present, 32'h1);
      check("t2_released", rl_or, 32'h000080);
      check("t2_pressed",  pr_or, 32'h0);
      check("t2_fv_n",     fv_n, 32'd1);

      // Load B+R, then a short frame must be rejected without side effects.
      send_bits({12'hFFF, 12'h801}, 24);
      latch_frame(1'b0);
      check("t3a_buttons", bus.buttons, 32'h000801);
      send_bits({12'h000, 12'h000}, 23);
      latch_frame(1'b0);
      check("t3_fe_n",     fe_n, 32'd1);
      check("t3_fv_n",     fv_n, 32'd0);
      check("t3_buttons",  bus.buttons, 32'h000801);
      check("t3_present",  bus.present, 32'h1);
      check("t3_pressed",  pr_or, 32'h0);
      check("t3_released", rl_or, 32'h0);

      // 24 bits, then pmod_clk and latch rise together: extra clock dropped.
      send_bits({12'h020, 12'h100}, 24);
      latch_frame(1'b1);
      check("t4_fv_n",     fv_n, 32'd1);
      check("t4_fe_n",     fe_n, 32'd0);
      check("t4_buttons",  bus.buttons, 32'h020100);
      check("t4_present",  bus.present, 32'h3);
      check("t4_pressed",  pr_or, 32'h020100);
      check("t4_released", rl_or, 32'h000801);

      // Hold down for 8 frames.
`ifdef GAMEPAD_AUTOREPEAT_EN
      rpt_exp = 8'b1010_1001;
`else
      rpt_exp = 8'b0000_0001;
`endif
      for (int f = 0; f < 8; f++) begin
         send_bits({12'hFFF, 12'h040}, 24);
         latch_frame(1'b0);
         check($sformatf("t5_rpt_f%0d", f + 1), pr_or[6], rpt_exp[f]);
         check($sformatf("t5_other_f%0d", f + 1), pr_or & ~24'h000040, 32'h0);
      end
      check("t5_buttons", bus.buttons, 32'h000040);

      // Reset after 10 bits; the partial frame must be discarded.
      send_bits({12'hABC, 12'hDEF}, 10);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_rst_buttons", bus.buttons, 32'h0);
      check("t6_rst_present", bus.present, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_bits({12'hFFF, 12'h200}, 24);
      latch_frame(1'b0);
      check("t6_fe_n",    fe_n, 32'd0);
      check("t6_fv_n",    fv_n, 32'd1);
      check("t6_buttons", bus.buttons, 32'h000200);
      check("t6_present", bus.present, 32'h1);
      check("t6_pressed", pr_or, 32'h000200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
